// File: rtl/cache_way_ctrl.sv
// cache_way_ctrl: upstream controller for an array of tag_channel ways.
// It takes one CPU request at a time, broadcasts the address and the strobes to every way,
// and collects the per-way hit and tegOut results. A per-set FIFO pointer selects the
// replacement victim. On a miss, a dirty victim is written back first, and then the line is
// filled over a req/ack memory port.
//
// Ports:
//   clk_i, rst_ni            clock (rising edge), asynchronous active-low reset
//   req_valid_i/req_wr_i     CPU request valid, 1 = store
//   req_addr_i               CPU address {tag, index}
//   req_ready_o              idle, can accept a request
//   ch_addr_o                registered address broadcast to the ways
//   ch_wr_o/ch_md_o          fill strobe / modify (dirty) strobe
//   ch_index_o/ch_fifo_o     way-select value / replacement pointer of the current set
//   hit_all_o                OR of hit_vec_i (driven in LOOKUP)
//   hit_vec_i/teg_vec_i      per-way hit, per-way tegOut {val, mod, tag}
//   mem_req_o/mem_we_o       memory request, 1 = write-back, 0 = fill read
//   mem_addr_o/mem_ack_i     memory line address, 1-cycle completion pulse
//   resp_valid_o/resp_hit_o  1-cycle CPU completion pulse and hit flag
//
// Optional feature: define CACHE_WAY_CTRL_STATS_EN to add stat_hits_o, stat_misses_o
// (saturating 16-bit counters) and stat_err_o (sticky multi-hit flag).
module cache_way_ctrl #(
   parameter int unsigned ATEG_WIDTH   = 7,
   parameter int unsigned AINDEX_WIDTH = 6,
   parameter int unsigned ACH_WIDTH    = 3
) (
   input  logic                                          clk_i,
   input  logic                                          rst_ni,
   input  logic                                          req_valid_i,
   input  logic                                          req_wr_i,
   input  logic [ATEG_WIDTH+AINDEX_WIDTH-1:0]            req_addr_i,
   output logic                                          req_ready_o,
   output logic [ATEG_WIDTH+AINDEX_WIDTH-1:0]            ch_addr_o,
   output logic                                          ch_wr_o,
   output logic                                          ch_md_o,
   output logic [ACH_WIDTH-1:0]                          ch_index_o,
   output logic [ACH_WIDTH-1:0]                          ch_fifo_o,
   output logic                                          hit_all_o,
   input  logic [(2**ACH_WIDTH)-1:0]                     hit_vec_i,
   input  logic [(2**ACH_WIDTH)*(ATEG_WIDTH+2)-1:0]      teg_vec_i,
   output logic                                          mem_req_o,
   output logic                                          mem_we_o,
   output logic [ATEG_WIDTH+AINDEX_WIDTH-1:0]            mem_addr_o,
   input  logic                                          mem_ack_i,
`ifdef CACHE_WAY_CTRL_STATS_EN
   output logic [15:0]                                   stat_hits_o,
   output logic [15:0]                                   stat_misses_o,
   output logic                                          stat_err_o,
`endif
   output logic                                          resp_valid_o,
   output logic                                          resp_hit_o
);

   localparam int unsigned AW   = ATEG_WIDTH + AINDEX_WIDTH;
   localparam int unsigned SETS = 2 ** AINDEX_WIDTH;
   localparam int unsigned TW   = ATEG_WIDTH + 2;

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StLookup = 3'd1;
   localparam logic [2:0] StWb     = 3'd2;
   localparam logic [2:0] StFill   = 3'd3;
   localparam logic [2:0] StResp   = 3'd4;

   logic [2:0]            state_q, state_d;
   logic [AW-1:0]         ch_addr_q, ch_addr_d;
   logic                  req_wr_q, req_wr_d;
   logic                  resp_hit_q, resp_hit_d;
   logic [ATEG_WIDTH-1:0] victim_tag_q, victim_tag_d;
   logic [ACH_WIDTH-1:0]  fifo_mem_q [SETS];

   logic [AINDEX_WIDTH-1:0] set_idx;
   logic [ACH_WIDTH-1:0]    fifo_ptr;
   logic [TW-1:0]           victim;
   logic                    any_hit;
   logic                    fifo_we;

   assign set_idx  = ch_addr_q[AINDEX_WIDTH-1:0];
   assign fifo_ptr = fifo_mem_q[set_idx];
   // tegOut layout per way: {val, mod, tag}
   assign victim   = teg_vec_i[fifo_ptr*TW +: TW];
   assign any_hit  = |hit_vec_i;

   always_comb begin
      state_d      = state_q;
      ch_addr_d    = ch_addr_q;
      req_wr_d     = req_wr_q;
      resp_hit_d   = resp_hit_q;
      victim_tag_d = victim_tag_q;
      ch_wr_o      = 1'b0;
      ch_md_o      = 1'b0;
      fifo_we      = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
      case (state_q)
         StIdle: begin
            if (req_valid_i) begin
               ch_addr_d = req_addr_i;
               req_wr_d  = req_wr_i;
               state_d   = StLookup;
            end
         end
         StLookup: begin
            resp_hit_d = any_hit;
            if (any_hit) begin
               // A store hit tells the hitting way to mark itself dirty.
               ch_md_o = req_wr_q;
               state_d = StResp;
            end else begin
               victim_tag_d = victim[ATEG_WIDTH-1:0];
               state_d      = (victim[TW-1] && victim[TW-2]) ? StWb : StFill;
            end
         end
         StWb: begin
            mem_req_o  = 1'b1;
            mem_we_o   = 1'b1;
            mem_addr_o = {victim_tag_q, set_idx};
            if (mem_ack_i) state_d = StFill;
         end
         StFill: begin
            mem_req_o  = 1'b1;
            mem_addr_o = ch_addr_q;
            if (mem_ack_i) begin
               // A store miss fills the line already dirty.
               ch_wr_o = 1'b1;
               ch_md_o = req_wr_q;
               fifo_we = 1'b1;
               state_d = StResp;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         ch_addr_q    <= '0;
         req_wr_q     <= 1'b0;
         resp_hit_q   <= 1'b0;
         victim_tag_q <= '0;
      end else begin
         state_q      <= state_d;
         ch_addr_q    <= ch_addr_d;
         req_wr_q     <= req_wr_d;
         resp_hit_q   <= resp_hit_d;
         victim_tag_q <= victim_tag_d;
      end
   end

   // The replacement pointer advances only on a fill and wraps naturally at WAYS.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < SETS; s++) fifo_mem_q[s] <= '0;
      end else if (fifo_we) begin
         fifo_mem_q[set_idx] <= fifo_ptr + 1'b1;
      end
   end

   assign req_ready_o  = (state_q == StIdle);
   assign ch_addr_o    = ch_addr_q;
   assign ch_fifo_o    = fifo_ptr;
   assign ch_index_o   = fifo_ptr;
   assign hit_all_o    = (state_q == StLookup) && any_hit;
   assign resp_valid_o = (state_q == StResp);
   assign resp_hit_o   = (state_q == StResp) && resp_hit_q;

`ifdef CACHE_WAY_CTRL_STATS_EN
   logic [15:0] stat_hits_q, stat_misses_q;
   logic        stat_err_q;
   logic        in_lookup;

   assign in_lookup = (state_q == StLookup);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stat_hits_q   <= '0;
         stat_misses_q <= '0;
         stat_err_q    <= 1'b0;
      end else if (in_lookup) begin
         if (any_hit && stat_hits_q != 16'hFFFF) stat_hits_q <= stat_hits_q + 16'd1;
         if (!any_hit && stat_misses_q != 16'hFFFF) stat_misses_q <= stat_misses_q + 16'd1;
         // More than one bit set: clearing the lowest set bit leaves something behind.
         if ((hit_vec_i & (hit_vec_i - 1'b1)) != '0) stat_err_q <= 1'b1;
      end
   end

   assign stat_hits_o   = stat_hits_q;
   assign stat_misses_o = stat_misses_q;
   assign stat_err_o    = stat_err_q;
`endif

endmodule
